// File: rtl/pcpu_shift_pkg.sv
// Shared encodings and default sizes for the iterative EX-stage shifter.
// Optional rotate support is enabled by defining PCPU_SHIFT_ROTATE_EN.
package pcpu_shift_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int SHAMT_W_DEF = 5;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } sh_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_e;

endpackage

// File: rtl/pcpu_shift_step.sv
// Combinational single shift step of 0..STEP bits with the fill each op needs.
// Rotate is built only when PCPU_SHIFT_ROTATE_EN is defined; otherwise op 11 acts as SRL.
module pcpu_shift_step
  import pcpu_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int K_W   = 1
) (
  input  logic [WIDTH-1:0] i_data,
  input  sh_op_e           i_op,
  input  logic [K_W-1:0]   i_k,
  output logic [WIDTH-1:0] o_data
);

`ifdef PCPU_SHIFT_ROTATE_EN
  logic [2*WIDTH-1:0] w_rot;
  // Rotate right as a right shift of the doubled word.
  assign w_rot = {i_data, i_data} >> i_k;
`endif

  // Select the shifted value and fill for the requested op.
  always_comb begin
    o_data = i_data;
    case (i_op)
      SH_SLL: o_data = i_data << i_k;
      SH_SRL: o_data = i_data >> i_k;
      SH_SRA: o_data = $unsigned($signed(i_data) >>> i_k);
`ifdef PCPU_SHIFT_ROTATE_EN
      SH_ROR: o_data = w_rot[WIDTH-1:0];
`else
      SH_ROR: o_data = i_data >> i_k;
`endif
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/pcpu_iter_shifter.sv
// Multi-cycle iterative shifter (SLL/SRL/SRA, optional ROR) with start/busy/done handshake.
// Define PCPU_SHIFT_ROTATE_EN to give op 11 rotate-right semantics instead of SRL.
module pcpu_iter_shifter
  import pcpu_shift_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               flush,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int                 K_W    = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  sh_state_e          r_state;
  sh_state_e          w_next;
  sh_op_e             r_op;
  logic [WIDTH-1:0]   r_work;
  logic [WIDTH-1:0]   r_result;
  logic [SHAMT_W-1:0] r_count;
  logic [K_W-1:0]     w_k;
  logic [WIDTH-1:0]   w_step;
  logic               w_accept;
  logic               r_ready;
  logic               r_busy;
  logic               r_done;

  // Flush beats start, so an op is never accepted in a flush cycle.
  assign w_accept = start & r_ready & ~flush;

  // Bits consumed this cycle: min(STEP, remaining count).
  always_comb begin
    if (r_count > STEP_C) begin
      w_k = K_W'(STEP);
    end else begin
      w_k = K_W'(r_count);
    end
  end

  pcpu_shift_step #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_step (
    .i_data (r_work),
    .i_op   (r_op),
    .i_k    (w_k),
    .o_data (w_step)
  );

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = ST_IDLE;
    end else if (w_accept) begin
      w_next = (shamt == {SHAMT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_IDLE;
        ST_SHIFT: w_next = (r_count > STEP_C) ? ST_SHIFT : ST_DONE;
        ST_DONE:  w_next = ST_IDLE;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // State register and handshake outputs, registered from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next != ST_SHIFT);
      r_busy  <= (w_next == ST_SHIFT);
      r_done  <= (w_next == ST_DONE);
    end
  end

  // Datapath: load on accept, step while shifting, publish result on entry to DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_work   <= '0;
      r_op     <= SH_SLL;
      r_count  <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_count  <= '0;
    end else if (w_accept) begin
      r_work  <= operand;
      r_op    <= sh_op_e'(op);
      r_count <= shamt;
      if (shamt == {SHAMT_W{1'b0}}) begin
        r_result <= operand;
      end
    end else if (r_state == ST_SHIFT) begin
      r_work  <= w_step;
      r_count <= r_count - SHAMT_W'(w_k);
      if (w_next == ST_DONE) begin
        r_result <= w_step;
      end
    end
  end

  assign ready  = r_ready;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_pcpu_iter_shifter.sv
// Scoreboard bench for pcpu_iter_shifter (WIDTH=32, STEP=1); expected ROR value follows PCPU_SHIFT_ROTATE_EN.
module tb_pcpu_iter_shifter;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand;
  logic [4:0]  shamt;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int          n_cmp;
  int          n_err;
  int          busy_cyc;
  int          lat;
  logic [31:0] sb_q[$];
  logic [31:0] exp_ror;

  pcpu_iter_shifter #(
    .WIDTH   (32),
    .SHAMT_W (5),
    .STEP    (1)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .op      (op),
    .operand (operand),
    .shamt   (shamt),
    .flush   (flush),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result; busy cycles are tallied.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cyc++;
    if (done === 1'b1) begin
      if (sb_q.size() > 0) chk("result", result, sb_q.pop_front());
      else chk("spurious_done", 32'(done), 32'd0);
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                       input logic [31:0] e, input bit push);
    start = 1'b1; op = o; operand = d; shamt = s;
    if (push) sb_q.push_back(e);
    busy_cyc = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; busy_cyc = 0;
    start = 1'b0; op = 2'b00; operand = 32'd0; shamt = 5'd0; flush = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // SLL 1 by 4: latency 4, busy exactly 4 cycles.
    issue(2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010, 1'b1);
    wait_done(lat);
    chk("sll_lat", 32'(lat), 32'd4);
    chk("sll_busy", 32'(busy_cyc), 32'd4);
    @(posedge clk); #1;

    issue(2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat);
    chk("sra_lat", 32'(lat), 32'd31);
    @(posedge clk); #1;

    issue(2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b1);
    wait_done(lat);
    chk("srl_lat", 32'(lat), 32'd31);
    @(posedge clk); #1;

    // shamt 0 for every op: done next cycle, busy never high.
    for (int i = 0; i < 4; i++) begin
      issue(2'(i), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);
      wait_done(lat);
      chk("zero_lat", 32'(lat), 32'd0);
      chk("zero_busy", 32'(busy_cyc), 32'd0);
      @(posedge clk); #1;
    end

    // Start while busy is ignored.
    issue(2'b01, 32'h1234_5678, 5'd8, 32'h0012_3456, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    start = 1'b1; operand = 32'hFFFF_FFFF; op = 2'b00; shamt = 5'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 32'(lat), 32'd5);
    @(posedge clk); #1;

    // Flush a fresh op in its third cycle: back to IDLE, no done, result kept.
    issue(2'b00, 32'h0000_ABCD, 5'd10, 32'd0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_ready", 32'(ready), 32'd1);
    repeat (12) begin @(posedge clk); #1; end
    chk("flush_result", result, 32'h0012_3456);

`ifdef PCPU_SHIFT_ROTATE_EN
    exp_ror = 32'h1000_000F;
`else
    exp_ror = 32'h0000_000F;
`endif
    issue(2'b11, 32'h0000_00F1, 5'd4, exp_ror, 1'b1);
    wait_done(lat);
    chk("ror_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;

    // Asynchronous reset mid-SHIFT.
    issue(2'b00, 32'h0000_00FF, 5'd20, 32'd0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #2 rstn = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_result", result, 32'd0);
    #2 rstn = 1'b1;
    @(posedge clk); #1;

    // Back-to-back accept in the DONE cycle.
    issue(2'b00, 32'h0000_0003, 5'd2, 32'h0000_000C, 1'b1);
    wait_done(lat);
    chk("b2b_lat1", 32'(lat), 32'd2);
    chk("b2b_ready", 32'(ready), 32'd1);
    issue(2'b01, 32'h0000_0100, 5'd3, 32'h0000_0020, 1'b1);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    chk("b2b_lat2", 32'(lat), 32'd3);
    @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    chk("hold_result", result, 32'h0000_0020);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcpu_iter_shifter.md
Name: pcpu_iter_shifter

Overview:
- Multi-cycle iterative shift unit for the pipelined CPU EX stage.
- Provides all four shift flavours: SLL, SRL, SRA and the optional ROR. The single-cycle combinational shifter does not support SRL or ROR.
- Processes STEP bits per clock. It is used on the long-latency path and stalls the pipeline through its start/busy/done handshake.
- Sits beside the ALU. The hazard unit holds ID/EX while busy=1.

Parameters:
- WIDTH, 32, operand and result width.
- SHAMT_W, 5, shift-amount width (must equal clog2(WIDTH)).
- STEP, 1, maximum bits shifted per cycle. Legal values: 1, 2, 4, 8.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  request strobe; accepted only when ready=1.
- op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- operand  in  WIDTH  value to shift; sampled on accept.
- shamt  in  SHAMT_W  shift amount; sampled on accept.
- flush  in  1  pipeline flush; aborts any operation in progress.
- ready  out  1  high in IDLE or DONE.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse when result becomes valid.
- result  out  WIDTH  shifted value; held until the next accept.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, result=0, done=0, busy=0, ready=1, internal count=0, op register=SLL.
- States:
  - IDLE -> SHIFT on accept when shamt!=0.
  - IDLE -> DONE on accept when shamt==0.
  - SHIFT -> SHIFT while remaining count > STEP.
  - SHIFT -> DONE on the edge that consumes the last bits.
  - DONE -> IDLE after one cycle, unless a new start is accepted in the same cycle, which follows the IDLE accept rules.
- Accept = start & ready at a rising edge. On accept:
  - Latch operand into the working register, latch op, set count=shamt.
- Per-cycle step in SHIFT:
  - Shift amount k = min(STEP, count); count -= k.
  - SLL fills with 0. SRL fills with 0. SRA fills with working[WIDTH-1]. ROR rotates right.
- Latency: n = ceil(shamt/STEP). done is high in the cycle after edge (accept edge + n).
  - shamt=0: done is high in the cycle directly after the accept edge, and result=operand.
- done is high for exactly one cycle. result updates only on entry to DONE and is stable otherwise.
- start while busy=1 is ignored. No queueing, and the operand is not re-sampled.
- flush (synchronous, highest priority after reset):
  - Next state is IDLE, no done pulse, result keeps its previous value.
  - flush together with start in the same cycle: flush wins and start is not accepted.
- Reset asserted mid-operation: immediate return to reset values; the partial result is discarded.
- Arithmetic: all shifts are modulo nothing; shamt is always less than WIDTH by width.
  - SRA of a negative operand by WIDTH-1 yields all ones.
- Invalid op encoding 11 without the optional feature: executes as SRL.

Optional Feature:
- Macro PCPU_SHIFT_ROTATE_EN.
- Defined: op 11 performs rotate-right by shamt, one STEP per cycle. Latency is the same as the other ops.
- Undefined: no rotate logic is synthesised and op 11 decodes as SRL. All other behaviour is identical.

Decomposition:
- Shared package pcpu_shift_pkg holds:
  - Op encodings: SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROR=2'b11.
  - State encodings: ST_IDLE, ST_SHIFT, ST_DONE.
  - Default WIDTH/SHAMT_W constants.
- One natural sub-module: pcpu_shift_step. It is a combinational single step that takes data, op and k (0..STEP) and returns the shifted data with the correct fill.
- The FSM, counter and handshake stay in pcpu_iter_shifter.

Test Plan:
- SLL 0x0000_0001 by 4, STEP=1 -> done pulse 4 cycles after accept, result=0x0000_0010, busy high for exactly 4 cycles.
- SRA 0x8000_0000 by 31 -> result=0xFFFF_FFFF after 31 cycles. SRL with the same inputs -> result=0x0000_0001.
- shamt=0, operand 0xDEAD_BEEF, any op -> done in the cycle after accept, result=0xDEAD_BEEF, busy never high.
- SRL 0x1234_5678 by 8. Pulse start again mid-operation with operand 0xFFFF_FFFF -> second start ignored, result=0x0012_3456. Then assert flush on a fresh op at cycle 3 -> IDLE, no done, result still 0x0012_3456.
- ROR 0x0000_00F1 by 4, with PCPU_SHIFT_ROTATE_EN defined -> 0x1000_000F. Without the macro -> 0x0000_000F.
- Deassert rstn asynchronously mid-SHIFT -> outputs return to reset values immediately. A back-to-back accept in the DONE cycle starts the next op with no idle bubble.
